// File: rtl/stopwatch_ctrl.sv
// Control sequencer for a 4-digit BCD stopwatch: debounces the start/pause
// button, decodes the mode/preset, and paces the counter datapath.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 10
) (
  input  logic        clk,
  input  logic        R,
  input  logic        P,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic        tc,
  output logic        cnt_we,
  output logic [15:0] cnt_val,
  output logic        cnt_en,
  output logic        cnt_up,
  output logic        running,
  output logic        done
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TKW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;

  typedef enum logic [2:0] {S_INIT, S_READY, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           p_s1_q, p_s1_d, p_s2_q, p_s2_d;
  logic           db_lvl_q, db_lvl_d, db_prev_q, db_prev_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     sel_q, sel_d;
  logic [7:0]     load_q, load_d;
  logic [TKW-1:0] tick_q, tick_d;
  logic           press, sel_chg, load_chg, tick_hit;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Input conditioning: synchroniser, debounce, rising-edge detect
  always_comb begin
    p_s1_d    = P;
    p_s2_d    = p_s1_q;
    db_prev_d = db_lvl_q;
    db_lvl_d  = db_lvl_q;
    db_cnt_d  = '0;
    if (p_s2_q != db_lvl_q) begin
      if (db_cnt_q == DBW'(DB_CYCLES - 1)) db_lvl_d = p_s2_q;
      else                                 db_cnt_d = db_cnt_q + DBW'(1);
    end
    sel_d  = sel;
    load_d = load;
  end

  assign press    = db_lvl_q & ~db_prev_q;
  assign sel_chg  = (sel  != sel_q);
  assign load_chg = (load != load_q);
  assign tick_hit = (tick_q == TKW'(TICK_DIV - 1));

  // Start value and direction follow the registered mode, not the live pins
  always_comb begin
    cnt_val = 16'h0000;
    unique case (sel_q)
      2'b00: cnt_val = 16'h0000;
      2'b01: cnt_val = {clamp9(load_q[7:4]), clamp9(load_q[3:0]), 8'h00};
      2'b10: cnt_val = 16'h9999;
      2'b11: cnt_val = {clamp9(load_q[7:4]), clamp9(load_q[3:0]), 8'h00};
      default: cnt_val = 16'h0000;
    endcase
  end

  assign cnt_up = ~sel_q[1];

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_we  = 1'b0;
    cnt_en  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        cnt_we  = 1'b1;
        tick_d  = '0;
        state_d = load_chg ? S_INIT : S_READY;
      end
      S_READY: begin
        if (load_chg)   state_d = S_INIT;
        else if (press) state_d = S_RUN;
      end
      S_RUN: begin
        running = 1'b1;
        tick_d  = tick_hit ? '0 : tick_q + TKW'(1);
        // A pause landing on a tick still lets that step through
        cnt_en  = tick_hit & ~tc;
        if (press)                state_d = S_PAUSE;
        else if (tick_hit && tc)  state_d = S_DONE;
      end
      S_PAUSE: begin
        if (press) state_d = S_RUN;
      end
      S_DONE: begin
        done = 1'b1;
        if (load_chg) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
    // Mode change overrides everything; the counter is about to be reloaded
    if (sel_chg) begin
      state_d = S_INIT;
      cnt_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q   <= S_INIT;
      p_s1_q    <= 1'b0;
      p_s2_q    <= 1'b0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      sel_q     <= 2'b00;
      load_q    <= 8'h00;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      p_s1_q    <= p_s1_d;
      p_s2_q    <= p_s2_d;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_prev_d;
      db_cnt_q  <= db_cnt_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      tick_q    <= tick_d;
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the 4-digit BCD stopwatch counter datapath (SS.hh, 00.00–99.99). Debounces the start/pause pushbutton `P` and decodes the mode select `sel`. Initialises the counter with the correct start value and issues one count-enable per 1/100 s tick. It stops the count at the terminal value. It sits between the board inputs (button, switches) and the counter/display datapath.

## Interface
- `DB_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change on `P` (1_000_000 on hardware).
- `TICK_DIV`, default 10: clock cycles per 1/100 s count tick (1_000_000 at 100 MHz).
- `clk`  in  1  system clock, rising edge.
- `R`  in  1  reset; asynchronous, active-low.
- `P`  in  1  raw start/pause pushbutton, asynchronous, bouncy.
- `sel`  in  2  mode: 00 up from 00.00; 01 up from `load`.00; 10 down from 99.99; 11 down from `load`.00.
- `load`  in  8  two BCD digits forming the preset seconds field.
- `tc`  in  1  from datapath: counter at terminal (99.99 when counting up, 00.00 when counting down).
- `cnt_we`  out  1  datapath loads `cnt_val` this cycle.
- `cnt_val`  out  16  four BCD digits to load.
- `cnt_en`  out  1  single-cycle count step.
- `cnt_up`  out  1  1 = increment, 0 = decrement.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- Input conditioning: `P` → 2-flop synchroniser → debounce counter. The debounced level flips after `DB_CYCLES` consecutive samples that differ from the current level. Any agreeing sample clears the counter. `press` is a 1-cycle pulse on the debounced rising edge; releases produce no pulse.
- `sel` and `load` are registered each cycle into `sel_q` and `load_q`. A change is detected when the register input differs from the registered value.
- Preset sanitising: any `load` nibble > 9 is clamped to 9 (e.g. 8'hA3 → 93).
- `cnt_val` is Moore-decoded from `sel_q`/`load_q`:
  - 00 → 16'h0000
  - 01 → {load_q, 8'h00}
  - 10 → 16'h9999
  - 11 → {load_q, 8'h00}
- `cnt_up` = ~`sel_q`[1].
- States:
  - INIT: `cnt_we`=1 for one cycle; tick counter cleared; next state is READY.
  - READY: `press` → RUN.
  - RUN: `running`=1; the tick counter counts 0..`TICK_DIV`-1, and `cnt_en` pulses in the cycle it equals `TICK_DIV`-1. `press` → PAUSE. If `tc`=1 in a cycle where `cnt_en` would pulse, `cnt_en` is suppressed and the next state is DONE.
  - PAUSE: tick counter holds its value, so the tick phase is preserved on resume. `press` → RUN.
  - DONE: `done`=1; `press` is ignored.
- Priority, highest first:
  1. A `sel` change in any state → INIT.
  2. A `load` change in READY or DONE → INIT. In RUN/PAUSE a `load` change is ignored until the next INIT.
  3. `press`.
  4. Terminal count / tick.
- Simultaneous `press` and tick in RUN: the state goes to PAUSE, and that tick's `cnt_en` still fires.
- Mode 01 with `load`=99 (start at 99.00): runs to 99.99 then DONE. Mode 11 with `load`=00: `tc` is already 1, so the first tick goes straight to DONE with no `cnt_en`.

## Timing
- Reset (`R`=0): state INIT, so `cnt_we`=1. Other reset values: `sel_q`=00, `load_q`=00, `cnt_val`=16'h0000, `cnt_up`=1, `cnt_en`=0, `running`=0, `done`=0, debounce level 0, tick counter 0.
- The first rising edge after `R` deasserts moves the state to READY.
- Press latency: with `P` held high and first sampled at edge k, the `press` pulse is high during the cycle after edge k+`DB_CYCLES`+1. The state changes at the following edge.
- First `cnt_en` after entering RUN from READY: `TICK_DIV` cycles later. After that, exactly one pulse every `TICK_DIV` cycles.
- A `sel`/`load` change seen at edge k gives `cnt_we`=1 during cycle k+1, with the new `cnt_val`.
- Reset asserted mid-RUN immediately forces INIT outputs; there is no partial tick.

## Test plan
- Reset then mode 00, `TICK_DIV`=10: after reset, `cnt_we`=1 with `cnt_val`=0000. Hold `P` high for 10 cycles → RUN, with `cnt_en` every 10 cycles and `cnt_up`=1.
- Bounce: toggle `P` every 2 cycles for 20 cycles, then hold it high → exactly one `press`, one transition to RUN.
- Pause/resume: press in RUN at tick counter = 6 → PAUSE with no `cnt_en`. Press again → first `cnt_en` arrives 3 cycles after re-entering RUN.
- Mode 11, `load`=8'h01: `cnt_val`=0100, `cnt_up`=0. Run with `tc` driven high after 100 ticks → DONE, `cnt_en` suppressed on that tick, later presses ignored.
- `load`=8'hFA with `sel`=01 → `cnt_val`=9900. Change `sel` to 10 during RUN → INIT, `cnt_val`=9999, then READY.
- Assert `R` low during RUN → `running`=0, `cnt_we`=1, `cnt_en`=0 immediately (asynchronous).
